// File: rtl/command_sequencer.sv
// command_sequencer: records torque commands from the button stage and replays them in order.
// Define LOOP_PLAYBACK_EN to replay continuously until execute or clear stops playback.
module command_sequencer #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned CMD_W       = 18,
   parameter int unsigned STEP_CYCLES = 50000000
) (
   input  logic                       CLOCK50,
   input  logic                       rst_n,
   input  logic                       save,
   input  logic                       delete,
   input  logic                       clear,
   input  logic                       execute,
   input  logic [CMD_W-1:0]           cmd_in,
   output logic [CMD_W-1:0]           torque_out,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       done,
   output logic                       overflow
);

   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam int unsigned IdxW  = $clog2(DEPTH);
   localparam int unsigned StepW = $clog2(STEP_CYCLES + 1);

   localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

   typedef enum logic {StIdle, StPlay} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [StepW-1:0]  step_q, step_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic              mem_we;
   logic              last_step, last_idx;
   logic [CMD_W-1:0]  mem [DEPTH];

   assign last_step = (step_q == StepLast);
   assign last_idx  = ((CntW'(idx_q) + CntW'(1)) == count_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      step_d  = step_q;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      mem_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Only the highest-priority pulse acts; the rest are dropped.
            if (clear) begin
               count_d = '0;
            end else if (execute) begin
               if (count_q != '0) begin
                  state_d = StPlay;
                  idx_d   = '0;
                  step_d  = '0;
               end
            end else if (save) begin
               if (count_q == CntFull) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we  = 1'b1;
                  count_d = count_q + CntW'(1);
               end
            end else if (delete && (count_q != '0)) begin
               count_d = count_q - CntW'(1);
            end
         end
         StPlay: begin
            if (clear) begin
               state_d = StIdle;
               count_d = '0;
               idx_d   = '0;
               step_d  = '0;
`ifdef LOOP_PLAYBACK_EN
            end else if (execute) begin
               state_d = StIdle;
               idx_d   = '0;
               step_d  = '0;
`endif
            end else if (!last_step) begin
               step_d = step_q + StepW'(1);
            end else begin
               step_d = '0;
               if (!last_idx) begin
                  idx_d = idx_q + IdxW'(1);
               end else begin
                  idx_d  = '0;
                  done_d = 1'b1;
`ifndef LOOP_PLAYBACK_EN
                  state_d = StIdle;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
         idx_q   <= '0;
         step_q  <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   // Buffer RAM carries no reset so it can map onto block memory.
   always_ff @(posedge CLOCK50) begin
      if (mem_we) begin
         mem[count_q[IdxW-1:0]] <= cmd_in;
      end
   end

   assign busy       = (state_q == StPlay);
   assign torque_out = busy ? mem[idx_q] : '0;
   assign count      = count_q;
   assign full       = (count_q == CntFull);
   assign empty      = (count_q == '0);
   assign done       = done_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_command_sequencer.sv
// Bench for command_sequencer: elapsed-time playback model checked every cycle plus literal checks.
module tb_command_sequencer;

   localparam int DEPTH = 4;
   localparam int CMD_W = 18;
   localparam int STEP  = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             save = 1'b0, delete = 1'b0, clear = 1'b0, execute = 1'b0;
   logic [CMD_W-1:0] cmd_in = '0;
   logic [CMD_W-1:0] torque_out;
   logic             busy, full, empty, done, overflow;
   logic [2:0]       count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #10 clk = ~clk;

   command_sequencer #(
      .DEPTH       (DEPTH),
      .CMD_W       (CMD_W),
      .STEP_CYCLES (STEP)
   ) dut (
      .CLOCK50    (clk),
      .rst_n      (rst_n),
      .save       (save),
      .delete     (delete),
      .clear      (clear),
      .execute    (execute),
      .cmd_in     (cmd_in),
      .torque_out (torque_out),
      .busy       (busy),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .done       (done),
      .overflow   (overflow)
   );

   // Model: a list of saved commands and elapsed cycles since playback started.
   logic [CMD_W-1:0] m_buf [DEPTH];
   int m_cnt, m_t;
   bit m_play, m_done, m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_t    <= 0;
         m_play <= 1'b0;
         m_done <= 1'b0;
         m_ovf  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         m_ovf  <= 1'b0;
         if (clear) begin
            m_cnt  <= 0;
            m_play <= 1'b0;
         end else if (m_play) begin
`ifdef LOOP_PLAYBACK_EN
            if (execute) m_play <= 1'b0;
            else if (m_t + 1 == m_cnt * STEP) begin
               m_t    <= 0;
               m_done <= 1'b1;
            end else m_t <= m_t + 1;
`else
            if (m_t + 1 == m_cnt * STEP) begin
               m_play <= 1'b0;
               m_done <= 1'b1;
            end
            m_t <= m_t + 1;
`endif
         end else if (execute) begin
            if (m_cnt > 0) begin
               m_play <= 1'b1;
               m_t    <= 0;
            end
         end else if (save) begin
            if (m_cnt < DEPTH) begin
               m_buf[m_cnt] <= cmd_in;
               m_cnt        <= m_cnt + 1;
            end else m_ovf <= 1'b1;
         end else if (delete && m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [CMD_W-1:0] exp_t;
      exp_t = m_play ? m_buf[m_t / STEP] : '0;
      check("model_torque", 32'(torque_out), 32'(exp_t));
      check("model_busy", 32'(busy), 32'(m_play));
      check("model_count", 32'(count), m_cnt);
      check("model_full", 32'(full), 32'(m_cnt == DEPTH));
      check("model_empty", 32'(empty), 32'(m_cnt == 0));
      check("model_done", 32'(done), 32'(m_done));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) compare_all();
   end

   task automatic tick(input bit s, input bit d, input bit c, input bit e,
                       input logic [CMD_W-1:0] v);
      @(negedge clk);
      save = s; delete = d; clear = c; execute = e; cmd_in = v;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(0, 0, 0, 0, '0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_torque", 32'(torque_out), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      tick(1, 0, 0, 0, 18'h00A05);
      tick(1, 0, 0, 0, 18'h1F003);
      check("save2_count", 32'(count), 2);
      check("save2_empty", 32'(empty), 0);
      check("save2_torque", 32'(torque_out), 0);

      tick(0, 0, 0, 1, '0);
      check("play_first", 32'(torque_out), 32'h00A05);
      check("play_busy", 32'(busy), 1);
      idle(3);
      check("play_hold", 32'(torque_out), 32'h00A05);
      idle(1);
      check("play_second", 32'(torque_out), 32'h1F003);
      idle(3);
      check("play_second_hold", 32'(torque_out), 32'h1F003);
      idle(1);
`ifndef LOOP_PLAYBACK_EN
      check("end_busy", 32'(busy), 0);
      check("end_torque", 32'(torque_out), 0);
      check("end_done", 32'(done), 1);
      check("end_count", 32'(count), 2);
      idle(1);
      check("end_done_gone", 32'(done), 0);
`else
      check("loop_done1", 32'(done), 1);
      check("loop_busy1", 32'(busy), 1);
      check("loop_wrap", 32'(torque_out), 32'h00A05);
      idle(8);
      check("loop_done2", 32'(done), 1);
      check("loop_busy2", 32'(busy), 1);
      idle(1);
      tick(0, 0, 0, 1, '0);
      check("loop_stop_busy", 32'(busy), 0);
      check("loop_stop_done", 32'(done), 0);
      check("loop_stop_torque", 32'(torque_out), 0);
`endif

      tick(0, 0, 1, 0, '0);
      check("clr_count", 32'(count), 0);
      tick(1, 0, 0, 0, 18'h00011);
      tick(1, 0, 0, 0, 18'h00022);
      tick(1, 0, 0, 0, 18'h00033);
      tick(1, 0, 0, 0, 18'h00044);
      check("fill_count", 32'(count), 4);
      check("fill_full", 32'(full), 1);
      check("fill_no_ovf", 32'(overflow), 0);
      tick(1, 0, 0, 0, 18'h00055);
      check("ovf_pulse", 32'(overflow), 1);
      check("ovf_count", 32'(count), 4);
      idle(1);
      check("ovf_gone", 32'(overflow), 0);

      tick(0, 1, 0, 0, '0);
      tick(0, 1, 0, 0, '0);
      check("del_count", 32'(count), 2);
      tick(0, 0, 0, 1, '0);
      check("del_play0", 32'(torque_out), 32'h00011);
      idle(4);
      check("del_play1", 32'(torque_out), 32'h00022);
      idle(5);
      tick(0, 0, 1, 0, '0);
      tick(0, 1, 0, 0, '0);
      check("del_empty_count", 32'(count), 0);

      tick(1, 0, 0, 0, 18'h0002A);
      tick(1, 0, 0, 1, 18'h0003B);
      check("se_busy", 32'(busy), 1);
      check("se_count", 32'(count), 1);
      check("se_torque", 32'(torque_out), 32'h0002A);
      idle(2);
      tick(0, 0, 1, 0, '0);
      check("abort_busy", 32'(busy), 0);
      check("abort_torque", 32'(torque_out), 0);
      check("abort_count", 32'(count), 0);
      check("abort_done", 32'(done), 0);

      tick(0, 0, 0, 1, '0);
      check("exec0_busy", 32'(busy), 0);
      idle(2);
      check("exec0_done", 32'(done), 0);

      tick(1, 0, 0, 0, 18'h00007);
      tick(1, 1, 0, 0, 18'h00009);
      check("prio_save_over_del", 32'(count), 2);
      tick(0, 0, 1, 1, '0);
      check("prio_clear_count", 32'(count), 0);
      check("prio_clear_busy", 32'(busy), 0);

      tick(1, 0, 0, 0, 18'h00005);
      tick(0, 0, 0, 1, '0);
      idle(2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_torque", 32'(torque_out), 0);
      check("mid_rst_count", 32'(count), 0);
      check("mid_rst_empty", 32'(empty), 1);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
